codificador_funcionalidade_sincrono: RTL

Parametrised, clocked successor to the combinational functionality encoder. It samples an N-bit selection vector and requires every pattern to stay stable for a programmable number of cycles before committing it. Committed patterns are then classified as none, single-function or multiple-function, and translated into a binary function code with valid, change-strobe and error flags. The block sits between the raw selector inputs and the function-dispatch logic, so glitches and contact bounce never reach the code output.

---
 rtl/codificador_pkg.sv | 19 +
 rtl/codificador_funcionalidade_sincrono_if.sv | 35 +++
 rtl/classificador_entradas.sv | 38 +++
 rtl/codificador_funcionalidade_sincrono.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/codificador_pkg.sv
// Shared types for the synchronous functionality encoder.
//   estado_t : controller states (committed zero, filtering, committed code, committed error)
//   classe_t : classification of a selector pattern (no bit, one bit, several bits)
package codificador_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    FILTRANDO,
    VALIDO,
    ERRO
  } estado_t;

  typedef enum logic [1:0] {
    ZERO,
    UNICO,
    MULTIPLO
  } classe_t;

endpackage

// File: rtl/codificador_funcionalidade_sincrono_if.sv
// Selector/code bundle between the raw selector inputs and the encoder.
//   entradas      : selector vector, bit i selects function i+1
//   codigo        : committed function code, 0 = no function
//   codigo_valido : committed pattern maps to a function
//   novo_codigo   : one-cycle strobe when the committed outputs change
//   erro          : committed pattern is ambiguous (several bits, no priority)
// master drives the selectors; slave is the encoder.
interface codificador_funcionalidade_sincrono_if #(
  parameter int unsigned N_ENTRADAS = 7
);
  localparam int unsigned CW = $clog2(N_ENTRADAS + 1);

  logic [N_ENTRADAS-1:0] entradas;
  logic [CW-1:0]         codigo;
  logic                  codigo_valido;
  logic                  novo_codigo;
  logic                  erro;

  modport master (
    output entradas,
    input  codigo,
    input  codigo_valido,
    input  novo_codigo,
    input  erro
  );

  modport slave (
    input  entradas,
    output codigo,
    output codigo_valido,
    output novo_codigo,
    output erro
  );

endinterface

// File: rtl/classificador_entradas.sv
// Combinational classifier of a selector pattern.
//   padrao : pattern to classify
//   classe : ZERO / UNICO / MULTIPLO
//   codigo : (lowest set index)+1; forced to 0 for MULTIPLO unless priority mode is on
module classificador_entradas
  import codificador_pkg::*;
#(
  parameter int unsigned N_ENTRADAS      = 7,
  parameter int unsigned MODO_PRIORIDADE = 0,
  localparam int unsigned CW             = $clog2(N_ENTRADAS + 1)
) (
  input  logic [N_ENTRADAS-1:0] padrao,
  output classe_t               classe,
  output logic [CW-1:0]         codigo
);

  logic achou;
  logic multiplo;

  always_comb begin
    achou    = 1'b0;
    multiplo = 1'b0;
    codigo   = '0;
    // Scan from the top down so the last hit is the lowest index.
    for (int i = N_ENTRADAS - 1; i >= 0; i--) begin
      if (padrao[i]) begin
        if (achou) multiplo = 1'b1;
        achou  = 1'b1;
        codigo = CW'(i + 1);
      end
    end
    if (multiplo)   classe = MULTIPLO;
    else if (achou) classe = UNICO;
    else            classe = ZERO;
    if (multiplo && (MODO_PRIORIDADE == 0)) codigo = '0;
  end

endmodule

// File: rtl/codificador_funcionalidade_sincrono.sv
// Debounced, registered functionality encoder.
// A selector pattern must be seen unchanged for ESTAVEL_CICLOS consecutive cycles
// before it is committed and translated into a function code.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of the selector/code bundle (see interface header)
module codificador_funcionalidade_sincrono
  import codificador_pkg::*;
#(
  parameter int unsigned N_ENTRADAS      = 7,
  parameter int unsigned ESTAVEL_CICLOS  = 4,
  parameter int unsigned MODO_PRIORIDADE = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  codificador_funcionalidade_sincrono_if.slave  bus
);

  localparam int unsigned CW    = $clog2(N_ENTRADAS + 1);
  localparam int unsigned CNT_W = $clog2(ESTAVEL_CICLOS + 1);
  localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(ESTAVEL_CICLOS);

  logic [N_ENTRADAS-1:0] entradas_r;
  logic [N_ENTRADAS-1:0] padrao_comp_q, padrao_comp_d;
  logic [N_ENTRADAS-1:0] padrao_filt_q, padrao_filt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  estado_t               estado_q, estado_d;
  logic [CW-1:0]         codigo_q, codigo_d;
  logic                  valido_q, valido_d;
  logic                  novo_q, novo_d;
  logic                  erro_q, erro_d;

  logic                  filtrando;
  logic                  commit;
  classe_t               classe;
  logic [CW-1:0]         codigo_cls;

  // Classify the candidate as it will be held after this edge; on a commit edge
  // this equals entradas_r, so ESTAVEL_CICLOS=1 can commit straight from a
  // settled state without an extra cycle in FILTRANDO.
  classificador_entradas #(
    .N_ENTRADAS      (N_ENTRADAS),
    .MODO_PRIORIDADE (MODO_PRIORIDADE)
  ) u_classificador (
    .padrao (padrao_filt_d),
    .classe (classe),
    .codigo (codigo_cls)
  );

  // Stability filter: track the candidate and how long it has been seen.
  always_comb begin
    padrao_filt_d = padrao_filt_q;
    cnt_d         = cnt_q;
    filtrando     = 1'b0;
    case (estado_q)
      FILTRANDO: begin
        filtrando = 1'b1;
        if (entradas_r != padrao_filt_q) begin
          padrao_filt_d = entradas_r;
          cnt_d         = CNT_W'(1);
        end else if (cnt_q != CNT_ALVO) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (entradas_r != padrao_comp_q) begin
          filtrando     = 1'b1;
          padrao_filt_d = entradas_r;
          cnt_d         = CNT_W'(1);
        end
      end
    endcase
    commit = filtrando && (cnt_d == CNT_ALVO);
  end

  // Commit: settle the state from the class and update the registered outputs.
  always_comb begin
    estado_d      = filtrando ? FILTRANDO : estado_q;
    padrao_comp_d = padrao_comp_q;
    codigo_d      = codigo_q;
    valido_d      = valido_q;
    erro_d        = erro_q;
    novo_d        = 1'b0;
    if (commit) begin
      padrao_comp_d = padrao_filt_d;
      codigo_d      = '0;
      valido_d      = 1'b0;
      erro_d        = 1'b0;
      case (classe)
        UNICO: begin
          estado_d = VALIDO;
          codigo_d = codigo_cls;
          valido_d = 1'b1;
        end
        MULTIPLO: begin
          if (MODO_PRIORIDADE != 0) begin
            estado_d = VALIDO;
            codigo_d = codigo_cls;
            valido_d = 1'b1;
          end else begin
            estado_d = ERRO;
            erro_d   = 1'b1;
          end
        end
        default: estado_d = OCIOSO;
      endcase
      // A bounce back to the old pattern recommits without a strobe.
      novo_d = {codigo_d, valido_d, erro_d} != {codigo_q, valido_q, erro_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entradas_r    <= '0;
      padrao_comp_q <= '0;
      padrao_filt_q <= '0;
      cnt_q         <= '0;
      estado_q      <= OCIOSO;
      codigo_q      <= '0;
      valido_q      <= 1'b0;
      novo_q        <= 1'b0;
      erro_q        <= 1'b0;
    end else begin
      entradas_r    <= bus.entradas;
      padrao_comp_q <= padrao_comp_d;
      padrao_filt_q <= padrao_filt_d;
      cnt_q         <= cnt_d;
      estado_q      <= estado_d;
      codigo_q      <= codigo_d;
      valido_q      <= valido_d;
      novo_q        <= novo_d;
      erro_q        <= erro_d;
    end
  end

  assign bus.codigo        = codigo_q;
  assign bus.codigo_valido = valido_q;
  assign bus.novo_codigo   = novo_q;
  assign bus.erro          = erro_q;

endmodule
